// File: rtl/updown_driver_if.sv
// Command and counter-drive bundle for updown_driver: target handshake in,
// counter inst/reset strobes plus shadow/status out.
interface updown_driver_if #(
   parameter int WIDTH = 32
);
   // Handshake: a command transfers on a rising edge where tgt_valid && tgt_ready.
   // The source holds tgt_valid/tgt_data/tgt_clear stable until that edge;
   // tgt_ready depends only on driver state, never on tgt_valid.
   logic             tgt_valid;
   logic             tgt_ready;
   logic [WIDTH-1:0] tgt_data;
   logic             tgt_clear;
   logic             ctr_inst;
   logic             ctr_reset;
   logic [WIDTH-1:0] shadow;
   logic             at_target;
   logic             busy;

   modport master (
      output tgt_valid, tgt_data, tgt_clear,
      input  tgt_ready, ctr_inst, ctr_reset, shadow, at_target, busy
   );

   modport slave (
      input  tgt_valid, tgt_data, tgt_clear,
      output tgt_ready, ctr_inst, ctr_reset, shadow, at_target, busy
   );
endinterface

// File: rtl/updown_driver.sv
// Steps a free-running up/down counter to each commanded target along the
// shorter modular path, dithering target/target+1 once there.
module updown_driver #(
   parameter int WIDTH = 32
) (
   input  logic         clock,
   input  logic         reset,
   updown_driver_if.slave io_bus,
   output logic [1:0]   o_dbg_state
);

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_IDLE  = 2'd1,
      S_MOVE  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_target;
   logic [WIDTH-1:0] w_target_nxt;
   logic             r_dir;
   logic             w_dir_nxt;
   logic [WIDTH-1:0] r_shadow;
   logic [WIDTH-1:0] w_shadow_nxt;

   logic             w_on_target;
   logic             w_ctr_inst;
   logic             w_ctr_reset;
   logic             w_ready;
   logic             w_accept;
   logic [WIDTH-1:0] w_base;
   logic [WIDTH-1:0] w_dist;

   assign w_on_target = (r_shadow == r_target);

   // Outputs come from registered state only.
   always_comb begin
      w_ctr_reset = 1'b0;
      w_ctr_inst  = 1'b0;
      w_ready     = 1'b0;
      case (r_state)
         S_CLEAR: w_ctr_reset = 1'b1;
         S_IDLE: begin
            w_ctr_inst = w_on_target;
            w_ready    = w_on_target;
         end
         S_MOVE:  w_ctr_inst = r_dir;
         default: w_ctr_reset = 1'b1;
      endcase
   end

   assign w_shadow_nxt = w_ctr_reset ? '0 :
                         (w_ctr_inst ? r_shadow + 1'b1 : r_shadow - 1'b1);

   assign w_accept = io_bus.tgt_valid && w_ready;
   // Acceptance only happens on target, where the counter steps up this edge.
   assign w_base   = r_shadow + 1'b1;
   assign w_dist   = io_bus.tgt_data - w_base;

   always_comb begin
      w_state_nxt  = r_state;
      w_target_nxt = r_target;
      w_dir_nxt    = r_dir;
      case (r_state)
         S_CLEAR: w_state_nxt = S_IDLE;
         S_IDLE: begin
            if (w_accept) begin
               if (io_bus.tgt_clear) begin
                  w_target_nxt = '0;
                  w_state_nxt  = S_CLEAR;
               end else begin
                  w_target_nxt = io_bus.tgt_data;
                  if (w_dist != '0) begin
                     w_state_nxt = S_MOVE;
                     w_dir_nxt   = (w_dist <= HALF);
                  end
               end
            end
         end
         S_MOVE: begin
            if (w_shadow_nxt == r_target) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_CLEAR;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_CLEAR;
         r_target <= '0;
         r_dir    <= 1'b0;
         r_shadow <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_target <= w_target_nxt;
         r_dir    <= w_dir_nxt;
         r_shadow <= w_shadow_nxt;
      end
   end

   assign io_bus.tgt_ready = w_ready;
   assign io_bus.ctr_inst  = w_ctr_inst;
   assign io_bus.ctr_reset = w_ctr_reset;
   assign io_bus.shadow    = r_shadow;
   assign io_bus.at_target = (r_state == S_IDLE) && w_on_target;
   assign io_bus.busy      = (r_state != S_IDLE);
   assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_updown_driver.sv
// Directed bench for updown_driver at WIDTH=8 with a behavioural up/down
// counter model driven from ctr_inst/ctr_reset and compared to shadow.
module tb_updown_driver;
   localparam int W = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] dbg_state;

   updown_driver_if #(.WIDTH(W)) bus ();

   updown_driver #(.WIDTH(W)) dut (
      .clock       (clock),
      .reset       (reset),
      .io_bus      (bus.slave),
      .o_dbg_state (dbg_state)
   );

   always #5 clock = ~clock;

   int         tests  = 0;
   int         failed = 0;
   logic [W-1:0] m_cnt = '0;
   bit         m_valid = 1'b0;
   int         n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: the counter model follows what the driver presented before the edge.
   task automatic tick();
      logic i_s, r_s;
      i_s = bus.ctr_inst;
      r_s = bus.ctr_reset;
      @(posedge clock);
      #1;
      if (r_s) m_cnt = '0;
      else if (i_s) m_cnt = m_cnt + 1'b1;
      else m_cnt = m_cnt - 1'b1;
      if (r_s) m_valid = 1'b1;
      if (m_valid) chk("ctr_vs_shadow", 32'(bus.shadow), 32'(m_cnt));
   endtask

   task automatic send(input logic [W-1:0] data, input logic clr);
      int k;
      k = 0;
      while (!bus.tgt_ready && k < 4) begin
         tick();
         k++;
      end
      chk("send_ready", 32'(bus.tgt_ready), 32'd1);
      bus.tgt_valid = 1'b1;
      bus.tgt_data  = data;
      bus.tgt_clear = clr;
      tick();
      bus.tgt_valid = 1'b0;
      bus.tgt_clear = 1'b0;
   endtask

   task automatic wait_target(input int max, output int cnt);
      cnt = 0;
      while (!bus.at_target && cnt < max) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      bus.tgt_valid = 1'b0;
      bus.tgt_data  = '0;
      bus.tgt_clear = 1'b0;

      // Reset release
      tick();
      tick();
      reset = 1'b0;
      chk("rst_ctr_reset", 32'(bus.ctr_reset), 32'd1);
      chk("rst_ctr_inst",  32'(bus.ctr_inst),  32'd0);
      chk("rst_ready",     32'(bus.tgt_ready), 32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd1);
      chk("rst_at",        32'(bus.at_target), 32'd0);
      chk("rst_shadow",    32'(bus.shadow),    32'd0);
      chk("rst_state",     32'(dbg_state),     32'd0);
      tick();
      chk("idle_shadow0", 32'(bus.shadow),    32'd0);
      chk("idle_at0",     32'(bus.at_target), 32'd1);
      chk("idle_ready0",  32'(bus.tgt_ready), 32'd1);
      chk("idle_inst0",   32'(bus.ctr_inst),  32'd1);
      chk("idle_busy0",   32'(bus.busy),      32'd0);
      tick();
      chk("idle_shadow1", 32'(bus.shadow),    32'd1);
      chk("idle_at1",     32'(bus.at_target), 32'd0);
      chk("idle_ready1",  32'(bus.tgt_ready), 32'd0);
      chk("idle_inst1",   32'(bus.ctr_inst),  32'd0);
      tick();
      chk("dither_0",     32'(bus.shadow),    32'd0);
      chk("dither_at",    32'(bus.at_target), 32'd1);
      tick();
      chk("dither_1",     32'(bus.shadow),    32'd1);
      tick();
      chk("dither_0b",    32'(bus.shadow),    32'd0);

      // Short up move to 5
      send(8'd5, 1'b0);
      chk("up_acc_shadow", 32'(bus.shadow),    32'd1);
      chk("up_acc_state",  32'(dbg_state),     32'd2);
      chk("up_acc_inst",   32'(bus.ctr_inst),  32'd1);
      chk("up_acc_ready",  32'(bus.tgt_ready), 32'd0);
      tick();
      chk("up_s2", 32'(bus.shadow), 32'd2);
      tick();
      chk("up_s3", 32'(bus.shadow), 32'd3);
      tick();
      chk("up_s4", 32'(bus.shadow), 32'd4);
      chk("up_s4_busy", 32'(bus.busy), 32'd1);
      tick();
      chk("up_s5",      32'(bus.shadow),    32'd5);
      chk("up_s5_at",   32'(bus.at_target), 32'd1);
      chk("up_s5_busy", 32'(bus.busy),      32'd0);
      tick();
      chk("up_s6",    32'(bus.shadow),    32'd6);
      chk("up_s6_at", 32'(bus.at_target), 32'd0);
      tick();
      chk("up_s5b",   32'(bus.shadow),    32'd5);

      // Clear from shadow 5 (data ignored)
      send(8'h33, 1'b1);
      chk("clr_shadow6", 32'(bus.shadow),    32'd6);
      chk("clr_ctr_rst", 32'(bus.ctr_reset), 32'd1);
      chk("clr_state",   32'(dbg_state),     32'd0);
      tick();
      chk("clr_shadow0", 32'(bus.shadow),    32'd0);
      chk("clr_at",      32'(bus.at_target), 32'd1);

      // Wrap down to 250: d=249, 7 steps down through 0
      send(8'd250, 1'b0);
      chk("wrap_acc_shadow", 32'(bus.shadow),   32'd1);
      chk("wrap_acc_inst",   32'(bus.ctr_inst), 32'd0);
      wait_target(20, n);
      chk("wrap_len",    32'(n),           32'd7);
      chk("wrap_shadow", 32'(bus.shadow),  32'd250);
      chk("wrap_busy",   32'(bus.busy),    32'd0);

      send(8'd0, 1'b1);
      tick();
      chk("clr2_shadow0", 32'(bus.shadow), 32'd0);

      // Tie: d=128 goes up
      send(8'd129, 1'b0);
      chk("tie_inst",  32'(bus.ctr_inst), 32'd1);
      chk("tie_state", 32'(dbg_state),    32'd2);
      wait_target(300, n);
      chk("tie_len",    32'(n),          32'd128);
      chk("tie_shadow", 32'(bus.shadow), 32'd129);

      // 129 -> 3: d=129, down 127
      send(8'd3, 1'b0);
      chk("dn_inst", 32'(bus.ctr_inst), 32'd0);
      wait_target(300, n);
      chk("dn_len",    32'(n),          32'd127);
      chk("dn_shadow", 32'(bus.shadow), 32'd3);

      // Zero distance: 3 -> 4
      send(8'd4, 1'b0);
      chk("zero_shadow", 32'(bus.shadow),    32'd4);
      chk("zero_at",     32'(bus.at_target), 32'd1);
      chk("zero_busy",   32'(bus.busy),      32'd0);
      chk("zero_state",  32'(dbg_state),     32'd1);
      tick();
      chk("zero_dither", 32'(bus.shadow),    32'd5);

      // Held valid during a 15-step move
      send(8'd20, 1'b0);
      chk("held_acc_shadow", 32'(bus.shadow), 32'd5);
      bus.tgt_valid = 1'b1;
      bus.tgt_data  = 8'd10;
      n = 0;
      while (!bus.tgt_ready && n < 40) begin
         tick();
         n++;
      end
      chk("held_wait",   32'(n),          32'd15);
      chk("held_shadow", 32'(bus.shadow), 32'd20);
      tick();
      bus.tgt_valid = 1'b0;
      chk("held_acc2_shadow", 32'(bus.shadow),   32'd21);
      chk("held_acc2_inst",   32'(bus.ctr_inst), 32'd0);
      chk("held_acc2_state",  32'(dbg_state),    32'd2);
      wait_target(40, n);
      chk("held2_len",    32'(n),          32'd11);
      chk("held2_shadow", 32'(bus.shadow), 32'd10);

      // Reset 3 cycles into a 100-step move
      send(8'd111, 1'b0);
      chk("mid_acc_shadow", 32'(bus.shadow), 32'd11);
      tick();
      tick();
      tick();
      chk("mid_shadow14", 32'(bus.shadow), 32'd14);
      chk("mid_busy",     32'(bus.busy),   32'd1);
      reset   = 1'b1;
      m_valid = 1'b0;
      tick();
      reset = 1'b0;
      chk("mid_rst_shadow", 32'(bus.shadow),    32'd0);
      chk("mid_rst_ctr",    32'(bus.ctr_reset), 32'd1);
      chk("mid_rst_state",  32'(dbg_state),     32'd0);
      chk("mid_rst_ready",  32'(bus.tgt_ready), 32'd0);
      tick();
      chk("mid_idle_shadow", 32'(bus.shadow),    32'd0);
      chk("mid_idle_at",     32'(bus.at_target), 32'd1);
      chk("mid_idle_state",  32'(dbg_state),     32'd1);
      chk("mid_idle_ready",  32'(bus.tgt_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
